// File: rtl/cube_pkg.sv
// Shared types, widths and packing helper for the cube sequencer.
package cube_pkg;

    localparam int unsigned DATA_WID = 16;
    localparam int unsigned SIZE     = 8;
    localparam int unsigned ADDR_WID = 10;
    localparam int unsigned CNT_WID  = 10;
    localparam int unsigned MUL_LAT  = 2;
    localparam int unsigned ACC_WID  = 32;

    localparam int unsigned VEC_WID  = DATA_WID * SIZE;
    localparam int unsigned TILE_WID = ACC_WID * SIZE * SIZE;
    localparam int unsigned TAG_LEN  = 1 + MUL_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // One slot of the read-tracking pipeline.
    typedef struct packed {
        logic vld;
        logic first;
    } tag_t;

    // LSB of tile element (i,j) in the packed psum/result vectors.
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
        return (i * SIZE + j) * ACC_WID;
    endfunction

endpackage

// File: rtl/cube_if.sv
// Command, buffer-read, array and result signals of the cube sequencer.
interface cube_if;
    import cube_pkg::*;

    logic                 start;
    logic [CNT_WID-1:0]   k_len;
    logic [ADDR_WID-1:0]  wgt_base;
    logic [ADDR_WID-1:0]  ifm_base;
    logic                 busy;
    logic                 cfg_err;
    logic                 wgt_rd_en;
    logic                 ifm_rd_en;
    logic [ADDR_WID-1:0]  wgt_rd_addr;
    logic [ADDR_WID-1:0]  ifm_rd_addr;
    logic [VEC_WID-1:0]   wgt_rd_data;
    logic [VEC_WID-1:0]   ifm_rd_data;
    logic [VEC_WID-1:0]   weights;
    logic [VEC_WID-1:0]   pixels;
    logic [TILE_WID-1:0]  psums_in;
    logic [TILE_WID-1:0]  result_data;
    logic                 result_valid;
    logic                 result_ready;
    logic                 done;

    modport master (
        output start, k_len, wgt_base, ifm_base, wgt_rd_data, ifm_rd_data,
               psums_in, result_ready,
        input  busy, cfg_err, wgt_rd_en, ifm_rd_en, wgt_rd_addr, ifm_rd_addr,
               weights, pixels, result_data, result_valid, done
    );

    modport slave (
        input  start, k_len, wgt_base, ifm_base, wgt_rd_data, ifm_rd_data,
               psums_in, result_ready,
        output busy, cfg_err, wgt_rd_en, ifm_rd_en, wgt_rd_addr, ifm_rd_addr,
               weights, pixels, result_data, result_valid, done
    );

endinterface

// File: rtl/cube_acc_bank.sv
// SIZE x SIZE bank of 32-bit accumulators with load/add enables.
module cube_acc_bank
    import cube_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                add,
    input  logic [TILE_WID-1:0] psums,
    output logic [TILE_WID-1:0] acc
);

    // Load on the first step of a command, wrap-around add on later steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                for (int unsigned j = 0; j < SIZE; j++) begin
                    if (load) begin
                        acc[elem_lsb(i, j) +: ACC_WID] <= psums[elem_lsb(i, j) +: ACC_WID];
                    end else if (add) begin
                        acc[elem_lsb(i, j) +: ACC_WID] <= acc[elem_lsb(i, j) +: ACC_WID]
                                                        + psums[elem_lsb(i, j) +: ACC_WID];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cube_ctrl.sv
// Cube sequencer: issues K buffer reads, tracks them through the array and
// presents the accumulated tile on a valid/ready port.
module cube_ctrl
    import cube_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    cube_if.slave bus
);

    state_t               state;
    logic [CNT_WID-1:0]   k_len_q;
    logic [CNT_WID-1:0]   k_cnt;
    logic [ADDR_WID-1:0]  wgt_base_q;
    logic [ADDR_WID-1:0]  ifm_base_q;
    logic [ADDR_WID-1:0]  wgt_addr;
    logic [ADDR_WID-1:0]  ifm_addr;
    logic                 rd_en;
    logic                 first_rd;
    logic                 busy;
    logic                 cfg_err;
    logic                 result_valid;
    tag_t                 tag_q [TAG_LEN];
    logic                 pipe_busy_c;
    logic                 acc_load_c;
    logic                 acc_add_c;
    logic [TILE_WID-1:0]  acc;

    // Reads still in flight that have not reached the final tag stage.
    always_comb begin
        pipe_busy_c = 1'b0;
        for (int unsigned t = 0; t < TAG_LEN - 1; t++) begin
            pipe_busy_c = pipe_busy_c | tag_q[t].vld;
        end
    end

    assign acc_load_c = tag_q[TAG_LEN-1].vld &  tag_q[TAG_LEN-1].first;
    assign acc_add_c  = tag_q[TAG_LEN-1].vld & ~tag_q[TAG_LEN-1].first;

    // Control FSM, address generation and tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_len_q      <= '0;
            k_cnt        <= '0;
            wgt_base_q   <= '0;
            ifm_base_q   <= '0;
            wgt_addr     <= '0;
            ifm_addr     <= '0;
            rd_en        <= 1'b0;
            first_rd     <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
            result_valid <= 1'b0;
            for (int unsigned t = 0; t < TAG_LEN; t++) begin
                tag_q[t] <= '0;
            end
        end else begin
            cfg_err  <= 1'b0;
            tag_q[0] <= '{vld: rd_en, first: rd_en & first_rd};
            for (int unsigned t = 1; t < TAG_LEN; t++) begin
                tag_q[t] <= tag_q[t-1];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            k_len_q    <= bus.k_len;
                            wgt_base_q <= bus.wgt_base;
                            ifm_base_q <= bus.ifm_base;
                            wgt_addr   <= bus.wgt_base;
                            ifm_addr   <= bus.ifm_base;
                            k_cnt      <= CNT_WID'(1);
                            rd_en      <= 1'b1;
                            first_rd   <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    first_rd <= 1'b0;
                    if (k_cnt == k_len_q) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        wgt_addr <= wgt_base_q + ADDR_WID'(k_cnt);
                        ifm_addr <= ifm_base_q + ADDR_WID'(k_cnt);
                        k_cnt    <= k_cnt + CNT_WID'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_busy_c) begin
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (bus.result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cube_acc_bank u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (acc_load_c),
        .add   (acc_add_c),
        .psums (bus.psums_in),
        .acc   (acc)
    );

    assign bus.busy         = busy;
    assign bus.cfg_err      = cfg_err;
    assign bus.wgt_rd_en    = rd_en;
    assign bus.ifm_rd_en    = rd_en;
    assign bus.wgt_rd_addr  = wgt_addr;
    assign bus.ifm_rd_addr  = ifm_addr;
    assign bus.weights      = bus.wgt_rd_data;
    assign bus.pixels       = bus.ifm_rd_data;
    assign bus.result_data  = acc;
    assign bus.result_valid = result_valid;
    // Acceptance is signalled in the handshake cycle itself.
    assign bus.done         = (state == OUT) & bus.result_ready;

endmodule

// File: tb/tb_cube_ctrl.sv
// Scoreboard bench for cube_ctrl with buffer and compute-array models.
module tb_cube_ctrl;
    import cube_pkg::*;

    logic clk;
    logic rst_n;
    cube_if bus ();

    cube_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mode   = 1'b0;   // 0: product w*p, 1: concatenation {w,p}

    logic [VEC_WID-1:0]  wmem [1 << ADDR_WID];
    logic [VEC_WID-1:0]  imem [1 << ADDR_WID];
    logic [VEC_WID-1:0]  wrd;
    logic [VEC_WID-1:0]  ird;
    logic [TILE_WID-1:0] arr_pipe [MUL_LAT];
    logic [TILE_WID-1:0] exp_q [$];
    logic [2*ADDR_WID-1:0] addr_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Array element operation used by both the array model and the reference.
    function automatic logic [31:0] op(input logic [DATA_WID-1:0] w, input logic [DATA_WID-1:0] p);
        if (mode) return {w, p};
        return 32'(w) * 32'(p);
    endfunction

    function automatic logic [TILE_WID-1:0] outer(input logic [VEC_WID-1:0] w, input logic [VEC_WID-1:0] p);
        logic [TILE_WID-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < SIZE; i++)
            for (int unsigned j = 0; j < SIZE; j++)
                t[elem_lsb(i, j) +: 32] = op(w[i*DATA_WID +: DATA_WID], p[j*DATA_WID +: DATA_WID]);
        return t;
    endfunction

    // Reference: sum over K steps of the outer products read from the buffers.
    function automatic logic [TILE_WID-1:0] ref_tile(input int k, input logic [ADDR_WID-1:0] wb,
                                                     input logic [ADDR_WID-1:0] ib);
        logic [TILE_WID-1:0] t;
        logic [TILE_WID-1:0] p;
        logic [ADDR_WID-1:0] wa;
        logic [ADDR_WID-1:0] ia;
        t = '0;
        for (int s = 0; s < k; s++) begin
            wa = wb + ADDR_WID'(s);
            ia = ib + ADDR_WID'(s);
            p  = outer(wmem[wa], imem[ia]);
            for (int e = 0; e < int'(SIZE * SIZE); e++)
                t[e*32 +: 32] = t[e*32 +: 32] + p[e*32 +: 32];
        end
        return t;
    endfunction

    function automatic logic [VEC_WID-1:0] rvec();
        logic [VEC_WID-1:0] v;
        for (int q = 0; q < int'(VEC_WID / 32); q++) v[q*32 +: 32] = $urandom;
        return v;
    endfunction

    // Buffer models: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.wgt_rd_en) wrd <= wmem[bus.wgt_rd_addr];
        if (bus.ifm_rd_en) ird <= imem[bus.ifm_rd_addr];
    end
    assign bus.wgt_rd_data = wrd;
    assign bus.ifm_rd_data = ird;

    // Compute-array model: MUL_LAT cycles from operands to psums.
    always @(posedge clk) begin
        arr_pipe[0] <= outer(bus.weights, bus.pixels);
        for (int m = 1; m < int'(MUL_LAT); m++) arr_pipe[m] <= arr_pipe[m-1];
    end
    assign bus.psums_in = arr_pipe[MUL_LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tile_chk(input string name, input logic [TILE_WID-1:0] act, input logic [TILE_WID-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int e = int'(SIZE * SIZE) - 1; e >= 0; e--)
            if (act[e*32 +: 32] !== exp[e*32 +: 32]) bad = e;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s elem=%0d act=%h exp=%h t=%0t", name, bad,
                     act[bad*32 +: 32], exp[bad*32 +: 32], $time);
        end
    endtask

    // Monitor: read addresses and accepted tiles checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wgt_rd_en || bus.ifm_rd_en) begin
                chk("rd_en_pair", {bus.wgt_rd_en, bus.ifm_rd_en}, 64'h3);
                if (addr_q.size() == 0) begin
                    chk("rd_extra", 64'd1, 64'd0);
                end else begin
                    chk("rd_addr", 64'({bus.wgt_rd_addr, bus.ifm_rd_addr}), 64'(addr_q.pop_front()));
                end
            end
            if (bus.result_valid && bus.result_ready) begin
                chk("done_on_accept", 64'(bus.done), 64'd1);
                if (exp_q.size() == 0) chk("tile_extra", 64'd1, 64'd0);
                else tile_chk("tile", bus.result_data, exp_q.pop_front());
            end else if (bus.done) begin
                chk("spurious_done", 64'(bus.done), 64'd0);
            end
        end
    end

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic push_cmd(input int k, input logic [ADDR_WID-1:0] wb, input logic [ADDR_WID-1:0] ib);
        logic [ADDR_WID-1:0] wa;
        logic [ADDR_WID-1:0] ia;
        exp_q.push_back(ref_tile(k, wb, ib));
        for (int s = 0; s < k; s++) begin
            wa = wb + ADDR_WID'(s);
            ia = ib + ADDR_WID'(s);
            addr_q.push_back({wa, ia});
        end
    endtask

    // One full command: start, optional start-poke in ISSUE, hold, accept.
    task automatic run_cmd(input int k, input logic [ADDR_WID-1:0] wb, input logic [ADDR_WID-1:0] ib,
                           input int rdy_dly, input bit poke);
        int cyc;
        logic [TILE_WID-1:0] exp;
        exp = ref_tile(k, wb, ib);
        push_cmd(k, wb, ib);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.k_len = CNT_WID'(k);
        bus.wgt_base = wb;
        bus.ifm_base = ib;
        bus.result_ready = (rdy_dly == 0);
        @(negedge clk);
        cyc = 1;
        while (1) begin
            @(posedge clk); #1;
            if (poke && cyc == 2) begin
                bus.start = 1'b1;
                bus.k_len = CNT_WID'(7);
                bus.wgt_base = wb + ADDR_WID'(300);
                bus.ifm_base = ib + ADDR_WID'(300);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) chk("busy_running", 64'(bus.busy), 64'd1);
            if (bus.result_valid) break;
            cyc++;
            if (cyc > 2000) begin
                chk("valid_timeout", 64'd0, 64'd1);
                finish_now();
            end
        end
        chk("latency", 64'(cyc), 64'(k + 2 + int'(MUL_LAT)));
        if (rdy_dly > 0) begin
            for (int d = 0; d < rdy_dly; d++) begin
                chk("hold_valid", 64'(bus.result_valid), 64'd1);
                tile_chk("hold_data", bus.result_data, exp);
                @(posedge clk); #1;
                if (d == rdy_dly - 1) bus.result_ready = 1'b1;
                @(negedge clk);
            end
        end
        chk("done_pulse", 64'(bus.done), 64'd1);
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        @(negedge clk);
        chk("idle_after", 64'({bus.busy, bus.result_valid, bus.done}), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, 64'({bus.busy, bus.wgt_rd_en, bus.ifm_rd_en, bus.result_valid, bus.done,
                       bus.cfg_err, bus.wgt_rd_addr, bus.ifm_rd_addr}), 64'd0);
        tile_chk(name, bus.result_data, '0);
    endtask

    initial begin
        logic [VEC_WID-1:0] v;
        logic [VEC_WID-1:0] u;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.wgt_base = '0;
        bus.ifm_base = '0;
        bus.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // K=1, all 2 x all 3.
        v = '0; u = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            v[i*DATA_WID +: DATA_WID] = 16'd2;
            u[i*DATA_WID +: DATA_WID] = 16'd3;
        end
        wmem[0] = v; imem[0] = u;
        run_cmd(1, '0, '0, 0, 1'b0);

        // K=4, products 1..4 only on element (0,0).
        for (int s = 0; s < 4; s++) begin
            v = '0; u = '0;
            v[0 +: DATA_WID] = DATA_WID'(s + 1);
            u[0 +: DATA_WID] = 16'd1;
            wmem[100 + s] = v; imem[200 + s] = u;
        end
        run_cmd(4, ADDR_WID'(100), ADDR_WID'(200), 2, 1'b0);

        // Address wrap at the top of the buffer.
        for (int s = 0; s < 4; s++) begin
            wmem[ADDR_WID'(1022 + s)] = rvec();
            imem[ADDR_WID'(1021 + s)] = rvec();
        end
        run_cmd(4, ADDR_WID'(1022), ADDR_WID'(1021), 1, 1'b0);

        // k_len==0: cfg_err pulse, no activity.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.k_len = '0;
        @(negedge clk);
        chk("cfg_err_busy0", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", 64'({bus.cfg_err, bus.busy, bus.wgt_rd_en}), 64'h4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cfg_err_clear", 64'({bus.cfg_err, bus.busy}), 64'd0);

        // Start pulse during ISSUE must be ignored.
        for (int s = 0; s < 5; s++) begin
            wmem[ADDR_WID'(400 + s)] = rvec();
            imem[ADDR_WID'(500 + s)] = rvec();
        end
        run_cmd(5, ADDR_WID'(400), ADDR_WID'(500), 0, 1'b1);

        // 32-bit wrap with 0x8000_0000 products, ready held off 5 cycles.
        mode = 1'b1;
        for (int s = 0; s < 2; s++) begin
            v = '0; u = '0;
            v[0 +: DATA_WID] = 16'h8000;
            u[DATA_WID +: DATA_WID] = 16'h0001;
            wmem[50 + s] = v; imem[60 + s] = u;
        end
        run_cmd(2, ADDR_WID'(50), ADDR_WID'(60), 5, 1'b0);
        mode = 1'b0;

        // Reset in the middle of ISSUE, then a fresh K=2 command.
        for (int s = 0; s < 20; s++) begin
            wmem[ADDR_WID'(700 + s)] = rvec();
            imem[ADDR_WID'(800 + s)] = rvec();
        end
        push_cmd(20, ADDR_WID'(700), ADDR_WID'(800));
        @(posedge clk); #1;
        bus.start = 1'b1; bus.k_len = CNT_WID'(20);
        bus.wgt_base = ADDR_WID'(700); bus.ifm_base = ADDR_WID'(800);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        chk_outputs_zero("reset_mid_issue");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            wmem[ADDR_WID'(900 + s)] = rvec();
            imem[ADDR_WID'(950 + s)] = rvec();
        end
        run_cmd(2, ADDR_WID'(900), ADDR_WID'(950), 1, 1'b0);

        // Randomized commands.
        for (int n = 0; n < 12; n++) begin
            int k;
            logic [ADDR_WID-1:0] wb;
            logic [ADDR_WID-1:0] ib;
            k  = int'($urandom_range(1, 12));
            wb = ADDR_WID'($urandom);
            ib = ADDR_WID'($urandom);
            mode = 1'($urandom_range(0, 1));
            for (int s = 0; s < k; s++) begin
                wmem[wb + ADDR_WID'(s)] = rvec();
                imem[ib + ADDR_WID'(s)] = rvec();
            end
            run_cmd(k, wb, ib, int'($urandom_range(0, 3)), (k >= 3) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
        finish_now();
    end

endmodule

// File: doc/cube_ctrl.md
# cube_ctrl

Sequencer for the SIZE×SIZE outer-product compute array. On a start command it streams K weight/pixel vector pairs from the weight and input-feature-map buffers into the array, accumulates the SIZE×SIZE 32-bit products over K steps in an internal accumulator bank, and presents the finished partial-sum tile on a valid/ready output. It sits between the on-chip buffers, the compute array and the writeback path of the sDavinci cube unit.

## Interface
- DATA_WID, 16, element width of weights and pixels
- SIZE, 8, vector length; array is SIZE×SIZE
- ADDR_WID, 10, buffer address width
- CNT_WID, 10, width of reduction length k_len
- MUL_LAT, 2, compute-array latency in cycles from operand input to psum output (≥1)

- clock  in  1  system clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command pulse; accepted only in IDLE
- k_len  in  CNT_WID  number of vector pairs to accumulate; sampled with start
- wgt_base  in  ADDR_WID  first weight-buffer address; sampled with start
- ifm_base  in  ADDR_WID  first ifm-buffer address; sampled with start
- busy  out  1  high in every state except IDLE
- cfg_err  out  1  one-cycle pulse: start with k_len==0
- wgt_rd_en / ifm_rd_en  out  1  buffer read strobes, always asserted together
- wgt_rd_addr / ifm_rd_addr  out  ADDR_WID  read addresses
- wgt_rd_data / ifm_rd_data  in  DATA_WID*SIZE  buffer read data, valid one cycle after rd_en
- weights / pixels  out  DATA_WID*SIZE  array operands; combinational pass-through of rd_data
- psums_in  in  32*SIZE*SIZE  array products, element (i,j) at bits [(i*SIZE+j)*32 +: 32]
- result_data  out  32*SIZE*SIZE  accumulated tile, same packing
- result_valid  out  1  tile valid; held until accepted
- result_ready  in  1  downstream accept
- done  out  1  one-cycle pulse on the cycle the tile is accepted

## Operation
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: start && k_len!=0 → latch k_len and bases, clear k_cnt, go ISSUE. start && k_len==0 → pulse cfg_err, stay IDLE.
- ISSUE: assert rd_en, addr = base + k_cnt (modulo 2^ADDR_WID wrap), k_cnt++; after the k_len-th read go DRAIN. No back-pressure; one read per cycle.
- Tag pipeline of length 1+MUL_LAT tracks each read; tag bit 0 marks the first read of the command.
- Accumulate when the tag emerges: first tag loads acc[i][j] = psum; later tags add acc += psum. Sums are 32-bit, wrap modulo 2^32 (no saturation).
- DRAIN: wait until the tag pipeline is empty, then go OUT.
- OUT: result_valid=1, result_data = acc (stable). On result_ready: pulse done, go IDLE. Acc keeps its value until the next command's first load.
- start outside IDLE ignored; result_ready outside OUT ignored.

## Timing
- Start accepted in cycle 0; rd_en cycles 1..K; last psum in cycle K+1+MUL_LAT; result_valid from cycle K+2+MUL_LAT.
- result_ready in the first valid cycle → done in that cycle, busy low and new start acceptable next cycle.
- Reset (any time, including mid-ISSUE/OUT): state IDLE, counters, tags and accumulators zero; all outputs 0 (busy, rd_en, result_valid, done, cfg_err, addresses, result_data).
- Operand outputs are zero-free pass-through; array inputs are don't-care when rd_en tag is absent.

## Structure
- Package cube_pkg: state enum, ACC_WID=32, array packing index helper.
- Sub-module cube_acc_bank: SIZE×SIZE 32-bit registers with load/add enable and async clear; controller owns FSM, counters, address generation and tag pipeline.

## Test plan
- K=1, wgt=all 2, ifm=all 3 (array products 6) → result_valid at cycle 1+MUL_LAT+2, every element 6, done on ready.
- K=4, products 1,2,3,4 per step on element (0,0), others 0 → acc(0,0)=10, rest 0; rd addresses base..base+3.
- wgt_base=1022, K=4, ADDR_WID=10 → addresses 1022,1023,0,1.
- k_len=0 start → cfg_err one cycle, busy stays 0; start during ISSUE ignored (address sequence unchanged).
- result_ready held low 5 cycles → result_valid and data stable; products 0x8000_0000 twice → element 0 (wrap).
- rst_n low mid-ISSUE → all outputs 0 immediately; subsequent K=2 command produces correct fresh sums.
